uart_rx_port: RTL
=================

# uart_rx_port

Memory-mapped UART receiver that sits upstream of the CPU load path, complementing the transmit-side UART peripheral. It recovers 8N1 bytes from the serial input with 16x oversampling and buffers them in a small byte FIFO. The CPU drains the FIFO through the shared MADDR/MDATA/MEN/MRW/MWAIT bus at base address 0x0000_0040.

## Interface
Parameters:
- `CLK`, 200000000: core clock frequency in Hz.
- `BAUD`, 115200: line rate.
- `OVS`, 16: oversampling factor.
- `DIV`, CLK/(BAUD*OVS) (108 with the defaults): clock cycles per oversample tick, using integer division.
- `DEPTH`, 16: FIFO depth in bytes. Must be a power of 2.

Ports:
- `clk`  in  1: core clock. The block uses one clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `MADDR`  in  32: bus address.
- `MDATA`  inout  32: bus data. Driven only on a selected read, otherwise `z`.
- `MEN`  in  1: bus access enable.
- `MRW`  in  1: 1 = write, 0 = read.
- `MWAIT`  out  1: driven 0 when selected, otherwise `z`.
- `rx`  in  1: serial input. Idles high.

## Operation
- **Select.** `sel = MEN && MADDR[31:4]==28'h000_0004`.
- **Register map, offset 0x0 (STATUS).**
  - Read returns {29'd0, overrun, frame_err, !empty}.
  - Write: MDATA[1]=1 clears frame_err. MDATA[2]=1 clears overrun. All other bits are ignored.
- **Register map, offset 0x4 (DATA).**
  - Read returns {24'd0, head byte} and pops one byte on that clock edge.
  - Read when the FIFO is empty returns 0 and does not pop.
  - Writes are ignored.
- **Offsets 0x8 and 0xC.** Read returns 0. Writes are ignored.
- **Single-cycle accesses.** MWAIT=0 completes every access in one cycle. A DATA read held for N cycles pops N bytes (the CPU never does this).
- **Synchronizer.** `rx` passes through a 2-flop synchronizer, reset to 1, producing `rx_s`.
- **Tick divider.** Counts 0..DIV-1 and emits `tick` on DIV-1. It is forced to 0 on every entry to START.
- **FSM states and transitions:**
  - IDLE: when `rx_s==0`, go to START and clear the tick count.
  - START: after OVS/2 ticks, sample `rx_s`. If 1, treat it as a glitch and return to IDLE. If 0, go to DATA with bit index 0.
  - DATA: every OVS ticks, sample `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after OVS ticks, sample `rx_s`.
    - Sample 1: push the byte. If the FIFO is full, drop the byte and set overrun. Go to IDLE.
    - Sample 0: discard the byte, set frame_err, go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE.
- **Sticky flags.** If a set and a clear of the same flag occur in one cycle, the set wins.
- **FIFO boundary cases.**
  - Push and pop in the same cycle while full: both happen and there is no overrun.
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored.
  - Pointers wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit.

## Timing
- **Reset values.**
  - FSM = IDLE. Tick count = 0. Shift register = 0.
  - FIFO empty. frame_err = 0. overrun = 0. Synchronizer flops = 1.
  - Therefore STATUS reads 0. MDATA and MWAIT are `z` whenever the block is not selected.
- **Read path.** Read data is combinational from MADDR and FIFO state in the access cycle. The pop takes effect at the end of that cycle.
- **Push latency.** A pushed byte is visible as STATUS[0]=1 in the cycle after the STOP sample edge.
- **End-to-end latency.** From the `rx` falling edge to `!empty` is 2 + DIV*(OVS/2 + 9*OVS) clock cycles, within ±DIV cycles.
- **Reset mid-frame.** Asserting `rst_n` low mid-frame aborts the frame immediately and loses the partial byte. After release, the FSM waits in IDLE for the next low on `rx_s`.

## Structure
- **Shared package:**
  - FSM state encoding: IDLE, START, DATA, STOP, BREAK.
  - Register offsets: STATUS=0x0, DATA=0x4.
  - Base address tag: 28'h000_0004.
  - STATUS bit positions.
- **Sub-module `rx_byte_fifo`** (DEPTH parameter):
  - Ports: `clk`, `rst_n`, `din[7:0]`, `wr_en`, `full`, `dout[7:0]`, `rd_en`, `empty`.
  - `dout` is the head byte, presented combinationally.
- **Top level** holds the synchronizer, tick divider, FSM and bus decode.

## Test plan
- **Single byte.** Send 0xA5 at BAUD.
  - STATUS reads 0x1.
  - DATA reads 0x0000_00A5.
  - STATUS then reads 0x0.
- **Overrun.** Send 17 bytes 0x00..0x10 with no reads.
  - STATUS reads 0x5.
  - 16 DATA reads return 0x00..0x0F in order; 0x10 is lost.
  - Writing 0x4 to STATUS makes it read 0x0.
- **Framing error.** Send a byte with stop bit 0, then hold `rx` low for 3 bit times.
  - Nothing is pushed. STATUS reads 0x2.
  - No spurious byte appears until `rx` returns high.
  - Writing 0x2 to STATUS clears the flag.
- **Glitch rejection.** Drive `rx` low for 3*DIV cycles.
  - FSM returns to IDLE and STATUS stays 0.
  - A following 0x3C is received correctly.
- **Simultaneous push/pop when full.** With the FIFO full, issue a DATA read on the exact push edge.
  - No overrun.
  - The popped byte is the oldest.
  - The new byte ends up at the tail.
- **Reset and address decode.** Assert `rst_n` low mid-byte, then release.
  - STATUS reads 0 and the FIFO is empty.
  - Accesses to 0x3C or 0x50 leave MDATA and MWAIT at `z`.
  - A subsequent 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_port_pkg.sv
// ============================================================================
// Module  : uart_rx_port_pkg
// Brief   : Shared receiver FSM encoding, register offsets and STATUS layout.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_rx_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam logic [3:0]  c_ofs_status = 4'h0;
  localparam logic [3:0]  c_ofs_data   = 4'h4;
  localparam logic [27:0] c_base_tag   = 28'h000_0004;

  localparam int c_stat_nempty = 0;
  localparam int c_stat_frame  = 1;
  localparam int c_stat_ovr    = 2;

endpackage

`default_nettype wire

// File: rtl/uart_rx_port_if.sv
// ============================================================================
// Module  : uart_rx_port_if
// Brief   : CPU load bus; MDATA/MWAIT are resolved here from each side's enables.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_rx_port_if;
  logic [31:0] MADDR;
  logic        MEN;
  logic        MRW;
  logic [31:0] wr_data;
  logic        wr_oe;
  logic [31:0] rd_data;
  logic        rd_oe;
  logic        wait_oe;
  wire  [31:0] MDATA;
  wire         MWAIT;

  assign MDATA = rd_oe ? rd_data : (wr_oe ? wr_data : 32'bz);
  assign MWAIT = wait_oe ? 1'b0 : 1'bz;

  modport master (output MADDR, MEN, MRW, wr_data, wr_oe, input MDATA, MWAIT);
  modport slave  (input MADDR, MEN, MRW, MDATA, output rd_data, rd_oe, wait_oe);
endinterface

`default_nettype wire

// File: rtl/uart_rx_port_rx_byte_fifo.sv
// ============================================================================
// Module  : rx_byte_fifo
// Brief   : Byte FIFO with combinational head output and extra-bit pointers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic [7:0] dout,
  input  logic       rd_en,
  output logic       empty
);
  localparam int c_aw = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  logic          w_do_wr;
  logic          w_do_rd;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                 (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign dout  = r_mem[r_rd_ptr[c_aw-1:0]];

  // A write into a full FIFO is accepted only when the head leaves on the same edge.
  assign w_do_rd = rd_en && !empty;
  assign w_do_wr = wr_en && (!full || w_do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_port.sv
// ============================================================================
// Module  : uart_rx_port
// Brief   : 8N1 UART receiver, 16x oversampled, with byte FIFO on the CPU bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int CLK   = 200000000,
  parameter int BAUD  = 115200,
  parameter int OVS   = 16,
  parameter int DIV   = CLK / (BAUD * OVS),
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_port_if.slave bus,
  input  logic          rx
);
  localparam int c_tw = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_ow = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [c_tw-1:0] c_tick_last = c_tw'(DIV - 1);
  localparam logic [c_ow-1:0] c_os_last   = c_ow'(OVS - 1);
  localparam logic [c_ow-1:0] c_os_half   = c_ow'(OVS / 2 - 1);

  logic            r_rx_meta, r_rx_s;
  logic [c_tw-1:0] r_tick_cnt;
  rx_state_t       r_state, w_state_nxt;
  logic [c_ow-1:0] r_os_cnt, w_os_nxt;
  logic [2:0]      r_bit_idx, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_frame_err, r_overrun;
  logic            w_tick, w_push, w_frame_set, w_ovr_set;
  logic            w_full, w_empty, w_pop;
  logic [7:0]      w_fifo_dout;
  logic            w_sel, w_rd, w_wr;
  logic [3:0]      w_ofs;
  logic [31:0]     w_rdata;
  logic            w_clr_frame, w_clr_ovr;
  logic            w_unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Restarting the divider on the falling edge aligns ticks to the start bit.
  assign w_tick = (r_tick_cnt == c_tick_last);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_tick_cnt <= '0;
    else if (r_state == ST_IDLE && !r_rx_s) r_tick_cnt <= '0;
    else if (w_tick)                      r_tick_cnt <= '0;
    else                                  r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = ST_START;
          w_os_nxt    = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_os_cnt == c_os_half) begin
            w_os_nxt = '0;
            if (r_rx_s) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_DATA;
              w_bit_nxt   = '0;
            end
          end else begin
            w_os_nxt = r_os_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_os_cnt == c_os_last) begin
            w_os_nxt    = '0;
            w_shift_nxt = {r_rx_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
            else                   w_bit_nxt   = r_bit_idx + 3'd1;
          end else begin
            w_os_nxt = r_os_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_os_cnt == c_os_last) begin
            w_os_nxt = '0;
            if (r_rx_s) begin
              w_push      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_frame_set = 1'b1;
              w_state_nxt = ST_BREAK;
            end
          end else begin
            w_os_nxt = r_os_cnt + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (r_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sel = bus.MEN && (bus.MADDR[31:4] == c_base_tag);
  assign w_rd  = w_sel && !bus.MRW;
  assign w_wr  = w_sel && bus.MRW;
  assign w_ofs = {bus.MADDR[3:2], 2'b00};
  assign w_pop = w_rd && (w_ofs == c_ofs_data) && !w_empty;

  assign w_ovr_set   = w_push && w_full && !w_pop;
  assign w_clr_frame = w_wr && (w_ofs == c_ofs_status) && bus.MDATA[c_stat_frame];
  assign w_clr_ovr   = w_wr && (w_ofs == c_ofs_status) && bus.MDATA[c_stat_ovr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_set | (r_frame_err & ~w_clr_frame);
      r_overrun   <= w_ovr_set   | (r_overrun   & ~w_clr_ovr);
    end
  end

  rx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (r_shift),
    .wr_en (w_push && (!w_full || w_pop)),
    .full  (w_full),
    .dout  (w_fifo_dout),
    .rd_en (w_pop),
    .empty (w_empty)
  );

  always_comb begin
    w_rdata = '0;
    if (w_ofs == c_ofs_status) begin
      w_rdata[c_stat_nempty] = !w_empty;
      w_rdata[c_stat_frame]  = r_frame_err;
      w_rdata[c_stat_ovr]    = r_overrun;
    end else if (w_ofs == c_ofs_data && !w_empty) begin
      w_rdata[7:0] = w_fifo_dout;
    end
  end

  assign bus.rd_data = w_rdata;
  assign bus.rd_oe   = w_rd;
  assign bus.wait_oe = w_sel;

  assign w_unused_bits = ^{bus.MDATA[31:3], bus.MDATA[0], bus.MADDR[1:0]};

endmodule

`default_nettype wire
